// File: rtl/gpio_in_filter_if.sv
// GPIO input conditioner bus: raw pins, edge/irq controls in;
// debounced levels, edge pulses, pending flags and irq out.
interface gpio_in_filter_if #(
  parameter int CH = 4
);
  logic [CH-1:0] gpio_in;
  logic [CH-1:0] edge_rise_en;
  logic [CH-1:0] edge_fall_en;
  logic [CH-1:0] irq_en;
  logic [CH-1:0] pend_clr;
  logic [CH-1:0] gpio_db;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic [CH-1:0] pend;
  logic          irq;

  modport master (
    output gpio_in,
    output edge_rise_en,
    output edge_fall_en,
    output irq_en,
    output pend_clr,
    input  gpio_db,
    input  rise,
    input  fall,
    input  pend,
    input  irq
  );

  modport slave (
    input  gpio_in,
    input  edge_rise_en,
    input  edge_fall_en,
    input  irq_en,
    input  pend_clr,
    output gpio_db,
    output rise,
    output fall,
    output pend,
    output irq
  );
endinterface

// File: rtl/gpio_in_filter.sv
// Per-channel 2-flop sync, debounce, rise/fall pulses, sticky pend, irq.
// Ports: clk, reset (async active-low), bus (gpio_in_filter_if.slave).
module gpio_in_filter #(
  parameter int   CH        = 4,
  parameter int   CNT_W     = 16,
  parameter int   DB_CYCLES = 50000,
  parameter logic INIT_LVL  = 1'b0
) (
  input logic            clk,
  input logic            reset,
  gpio_in_filter_if.slave bus
);

  localparam logic [CNT_W-1:0] DB_LAST =
    CNT_W'(DB_CYCLES - 1);

  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;
  logic [CH-1:0] r_db;
  logic [CH-1:0] r_rise;
  logic [CH-1:0] r_fall;
  logic [CH-1:0] r_pend;
  logic          r_irq;

  logic [CH-1:0] w_diff;
  logic [CH-1:0] w_acc;
  logic [CH-1:0] w_rise;
  logic [CH-1:0] w_fall;
  logic [CH-1:0] w_set;

  assign w_diff = r_sync2 ^ r_db;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;

    // accept once the mismatch has held DB_CYCLES samples
    assign w_acc[g] = w_diff[g] && (r_cnt == DB_LAST);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (!w_diff[g] || w_acc[g]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_rise = w_acc & r_sync2;
  assign w_fall = w_acc & ~r_sync2;
  assign w_set  = (bus.edge_rise_en & w_rise)
                | (bus.edge_fall_en & w_fall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= {CH{INIT_LVL}};
      r_sync2 <= {CH{INIT_LVL}};
      r_db    <= {CH{INIT_LVL}};
      r_rise  <= '0;
      r_fall  <= '0;
      r_pend  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_sync1 <= bus.gpio_in;
      r_sync2 <= r_sync1;
      r_db    <= r_db ^ w_acc;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      // set beats a same-cycle clear so no edge is lost
      r_pend  <= w_set | (r_pend & ~bus.pend_clr);
      r_irq   <= |(r_pend & bus.irq_en);
    end
  end

  assign bus.gpio_db = r_db;
  assign bus.rise    = r_rise;
  assign bus.fall    = r_fall;
  assign bus.pend    = r_pend;
  assign bus.irq     = r_irq;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter (CH=4, DB_CYCLES=4).
// Window-based reference model over the sampled pin history.
module tb_gpio_in_filter;

  localparam int   CH   = 4;
  localparam int   DB   = 4;
  localparam logic INIT = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [CH-1:0] pin_hist[$];
  logic [CH-1:0] m_db, m_rise, m_fall, m_pend;
  logic          m_irq;

  gpio_in_filter_if #(.CH(CH)) bus ();

  gpio_in_filter #(
    .CH(CH), .CNT_W(16), .DB_CYCLES(DB), .INIT_LVL(INIT)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    pin_hist.delete();
    m_db   = {CH{INIT}};
    m_rise = '0;
    m_fall = '0;
    m_pend = '0;
    m_irq  = 1'b0;
  endtask

  // one clock edge: capture inputs, update the model, settle
  task automatic tick();
    logic [CH-1:0] pin, ren, fen, ien, clr, acc, tmp;
    logic sv, stable;
    int k, e;
    pin = bus.gpio_in;
    ren = bus.edge_rise_en;
    fen = bus.edge_fall_en;
    ien = bus.irq_en;
    clr = bus.pend_clr;
    @(posedge clk);
    pin_hist.push_back(pin);
    k = pin_hist.size() - 1;
    acc = '0;
    for (int c = 0; c < CH; c++) begin
      stable = 1'b1;
      for (int j = 0; j < DB; j++) begin
        e = k - j;
        if (e < 0) begin
          stable = 1'b0;
        end else begin
          if (e >= 2) begin
            tmp = pin_hist[e-2];
            sv  = tmp[c];
          end else begin
            sv = INIT;
          end
          if (sv == m_db[c]) stable = 1'b0;
        end
      end
      acc[c] = stable;
    end
    m_irq  = |(m_pend & ien);
    m_rise = acc & ~m_db;
    m_fall = acc & m_db;
    m_pend = (ren & m_rise) | (fen & m_fall) | (m_pend & ~clr);
    m_db   = m_db ^ acc;
    #1;
  endtask

  task automatic apply_reset(input logic [CH-1:0] pins);
    rst_n = 1'b0;
    bus.gpio_in      = pins;
    bus.edge_rise_en = '0;
    bus.edge_fall_en = '0;
    bus.irq_en       = '0;
    bus.pend_clr     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    int e;
    rst_n = 1'b0;
    bus.gpio_in      = 4'hF;
    bus.edge_rise_en = '0;
    bus.edge_fall_en = '0;
    bus.irq_en       = '0;
    bus.pend_clr     = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.gpio_db !== 4'h0 || bus.pend !== 4'h0 ||
          bus.irq !== 1'b0 || bus.rise !== 4'h0) begin
        failures++;
        $display("FAIL reset_hold db=%h pend=%h irq=%b rise=%h want 0",
                 bus.gpio_db, bus.pend, bus.irq, bus.rise);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (e = 0; e <= 6; e++) begin
      tick();
      checks++;
      if (bus.gpio_db !== ((e >= 5) ? 4'hF : 4'h0) ||
          bus.rise !== ((e == 5) ? 4'hF : 4'h0)) begin
        failures++;
        $display("FAIL reset_release e=%0d db=%h rise=%h", e,
                 bus.gpio_db, bus.rise);
      end
      checks++;
      if (bus.gpio_db !== m_db || bus.rise !== m_rise) begin
        failures++;
        $display("FAIL reset_model e=%0d db=%h/%h rise=%h/%h", e,
                 bus.gpio_db, m_db, bus.rise, m_rise);
      end
    end
    // async reset mid-count discards the partial count
    apply_reset(4'h0);
    repeat (3) tick();
    bus.gpio_in = 4'h1;
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.gpio_db !== 4'h0 || bus.rise !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid db=%h rise=%h want 0",
               bus.gpio_db, bus.rise);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (e = 0; e <= 5; e++) begin
      tick();
      checks++;
      if (bus.rise[0] !== (e == 5)) begin
        failures++;
        $display("FAIL reset_restart e=%0d rise0=%b",
                 e, bus.rise[0]);
      end
    end
  endtask

  task automatic test_glitch();
    apply_reset(4'h0);
    bus.edge_rise_en = 4'hF;
    repeat (3) tick();
    bus.gpio_in = 4'h1;
    repeat (3) tick();
    bus.gpio_in = 4'h0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus.gpio_db[0] !== 1'b0 || bus.rise[0] !== 1'b0 ||
          bus.pend[0] !== 1'b0 || bus.gpio_db !== m_db) begin
        failures++;
        $display("FAIL glitch i=%0d db=%h rise=%h pend=%h want 0",
                 i, bus.gpio_db, bus.rise, bus.pend);
      end
    end
  endtask

  task automatic test_bounce();
    int t0, hit, nr;
    apply_reset(4'h0);
    bus.edge_rise_en = 4'hF;
    repeat (3) tick();
    bus.gpio_in = 4'h2;
    repeat (2) tick();
    bus.gpio_in = 4'h0;
    repeat (2) tick();
    bus.gpio_in = 4'h2;
    t0 = pin_hist.size();
    hit = -1;
    nr = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.rise[1]) nr++;
      if (hit < 0 && bus.gpio_db[1]) hit = pin_hist.size() - 1;
      checks++;
      if (bus.gpio_db !== m_db || bus.rise !== m_rise) begin
        failures++;
        $display("FAIL bounce_model i=%0d db=%h/%h", i,
                 bus.gpio_db, m_db);
      end
    end
    checks++;
    if (hit - t0 !== DB + 1) begin
      failures++;
      $display("FAIL bounce_latency got=%0d want=%0d",
               hit - t0, DB + 1);
    end
    checks++;
    if (nr !== 1) begin
      failures++;
      $display("FAIL bounce_pulses got=%0d want=1", nr);
    end
  endtask

  task automatic test_pend_irq();
    apply_reset(4'h4);
    bus.edge_fall_en = 4'h4;
    bus.irq_en       = 4'h4;
    repeat (8) tick();
    checks++;
    if (bus.gpio_db[2] !== 1'b1 || bus.pend !== 4'h0) begin
      failures++;
      $display("FAIL pend_pre db=%h pend=%h", bus.gpio_db, bus.pend);
    end
    bus.gpio_in = 4'h0;
    repeat (5) tick();
    tick();
    checks++;
    if (bus.fall[2] !== 1'b1 || bus.pend[2] !== 1'b1 ||
        bus.irq !== 1'b0 || bus.gpio_db[2] !== 1'b0) begin
      failures++;
      $display("FAIL pend_set fall=%h pend=%h irq=%b",
               bus.fall, bus.pend, bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1 || bus.fall !== 4'h0) begin
      failures++;
      $display("FAIL irq_set irq=%b fall=%h want 1/0",
               bus.irq, bus.fall);
    end
    bus.pend_clr = 4'h4;
    tick();
    bus.pend_clr = 4'h0;
    checks++;
    if (bus.pend[2] !== 1'b0 || bus.irq !== 1'b1) begin
      failures++;
      $display("FAIL pend_clr pend=%h irq=%b want 0/1",
               bus.pend, bus.irq);
    end
    tick();
    checks++;
    if (bus.irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_clr irq=%b want 0", bus.irq);
    end
  endtask

  task automatic test_collision();
    apply_reset(4'h0);
    bus.edge_rise_en = 4'h8;
    repeat (3) tick();
    bus.gpio_in = 4'h8;
    repeat (5) tick();
    bus.pend_clr = 4'h8;
    tick();
    bus.pend_clr = 4'h0;
    checks++;
    if (bus.rise[3] !== 1'b1 || bus.pend[3] !== 1'b1) begin
      failures++;
      $display("FAIL collide rise=%h pend=%h want 8/8",
               bus.rise, bus.pend);
    end
    tick();
    checks++;
    if (bus.pend[3] !== 1'b1) begin
      failures++;
      $display("FAIL collide_hold pend=%h want 8", bus.pend);
    end
    bus.pend_clr = 4'h8;
    tick();
    bus.pend_clr = 4'h0;
    checks++;
    if (bus.pend !== 4'h0 || bus.pend !== m_pend) begin
      failures++;
      $display("FAIL collide_clr pend=%h want 0", bus.pend);
    end
  endtask

  task automatic test_mask();
    apply_reset(4'h0);
    bus.irq_en = 4'hF;
    repeat (3) tick();
    bus.gpio_in = 4'h1;
    repeat (5) tick();
    tick();
    checks++;
    if (bus.rise[0] !== 1'b1 || bus.pend !== 4'h0) begin
      failures++;
      $display("FAIL mask_rise rise=%h pend=%h want 1/0",
               bus.rise, bus.pend);
    end
    bus.irq_en       = 4'h0;
    bus.edge_rise_en = 4'h2;
    bus.gpio_in      = 4'h3;
    repeat (6) tick();
    checks++;
    if (bus.pend[1] !== 1'b1) begin
      failures++;
      $display("FAIL mask_pend pend=%h want 2", bus.pend);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.irq !== 1'b0) begin
        failures++;
        $display("FAIL mask_irq i=%0d irq=%b want 0", i, bus.irq);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    apply_reset(4'($urandom));
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        bus.gpio_in = bus.gpio_in ^ 4'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      if (i % 25 == 0) begin
        bus.edge_rise_en = 4'($urandom);
        bus.edge_fall_en = 4'($urandom);
        bus.irq_en       = 4'($urandom);
      end
      bus.pend_clr = ($urandom_range(0, 5) == 0) ?
                     4'($urandom) : 4'h0;
      tick();
      checks++;
      if (bus.gpio_db !== m_db || bus.rise !== m_rise ||
          bus.fall !== m_fall || bus.pend !== m_pend ||
          bus.irq !== m_irq) begin
        failures++;
        $display("FAIL random i=%0d db=%h/%h r=%h/%h f=%h/%h p=%h/%h q=%b/%b",
                 i, bus.gpio_db, m_db, bus.rise, m_rise, bus.fall,
                 m_fall, bus.pend, m_pend, bus.irq, m_irq);
      end
    end
    bus.pend_clr = 4'h0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_pend_irq();
    test_collision();
    test_mask();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Input conditioner between the chip-top `gpio_in` pins and the GPIO block inside `chip`.
- Each channel is processed in four steps:
  - synchronises the asynchronous pin into `clk`;
  - debounces it with a per-channel stability counter;
  - produces one-cycle rise/fall pulses;
  - keeps sticky edge-pending flags that drive a masked interrupt.
- The GPIO block reads the debounced levels and the pending flags. It clears pending flags with a per-bit write-1-to-clear strobe.

Parameters:
- CH, 4, number of input channels (matches `GPIO_IN_CH`).
- CNT_W, 16, width of each debounce counter.
- DB_CYCLES, 50000, consecutive stable cycles required to accept a new level. Legal range is 1 to 2^CNT_W.
- INIT_LVL, 1'b0, reset value of every debounced level.

Ports:
- clk  in  1  system clock from clk_gen.
- reset  in  1  asynchronous, active-low reset.
- gpio_in  in  CH  raw asynchronous pins.
- edge_rise_en  in  CH  per-channel enable for setting pending on a rising edge.
- edge_fall_en  in  CH  per-channel enable for setting pending on a falling edge.
- irq_en  in  CH  interrupt mask, 1 = enabled.
- pend_clr  in  CH  write-1-to-clear strobe for pend, one cycle wide.
- gpio_db  out  CH  debounced level.
- rise  out  CH  one-cycle pulse when gpio_db goes 0->1.
- fall  out  CH  one-cycle pulse when gpio_db goes 1->0.
- pend  out  CH  sticky edge-pending flags.
- irq  out  1  OR-reduction of (pend & irq_en), registered.

Behaviour:
- Reset (reset low, asynchronous), values held until reset is released:
  - sync1 = sync2 = INIT_LVL;
  - gpio_db = INIT_LVL;
  - all counters = 0;
  - rise = fall = pend = 0;
  - irq = 0.
- Reset asserted mid-count discards any partial count. After release, filtering restarts from gpio_db = INIT_LVL.
- Synchroniser: two flops per channel, sync1 <= gpio_in and sync2 <= sync1. Only sync2 feeds the filter logic.
- Debounce, per channel, evaluated at every rising clk edge:
  - If sync2 == gpio_db: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: gpio_db <= sync2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A mismatch that vanishes before acceptance resets cnt to 0. Accumulation is never partial.
- Latency: a pin change settled before edge E0 appears in sync2 after E1. gpio_db updates at edge E(DB_CYCLES+1), and is visible in the cycle after that edge.
- Glitches: any sync2 pulse shorter than DB_CYCLES cycles produces no gpio_db change.
- DB_CYCLES = 1: gpio_db follows sync2 with one extra cycle of delay.
- Edge pulses are registered on the same edge that updates gpio_db:
  - rise = 1 for one cycle if gpio_db goes 0->1;
  - fall = 1 for one cycle if gpio_db goes 1->0;
  - both are 0 otherwise, and never both 1.
- Pending flags, per bit, evaluated every edge:
  - set = (edge_rise_en & the condition that raises rise) | (edge_fall_en & the condition that raises fall);
  - if set: pend <= 1;
  - else if pend_clr: pend <= 0.
  - Set wins over a simultaneous clear, so no edge event is lost.
- pend rises on the same edge as the rise/fall pulse.
- irq <= |(pend & irq_en), one cycle after pend or irq_en changes.
- Counter never exceeds DB_CYCLES-1, so no wrap-around is possible.
- Channels are fully independent. Simultaneous events on several channels are all captured.

Test Plan:
- Reset check: hold reset low with DB_CYCLES=4, INIT_LVL=0 and gpio_in=4'hF.
  - Required: gpio_db=0, pend=0, irq=0 throughout reset.
  - Release reset: gpio_db=4'hF visible after edge 5 post-release (E0 = first edge after release).
  - rise=4'hF for exactly one cycle on that edge.
- Glitch filter: DB_CYCLES=4, gpio_in[0] driven high for 3 cycles, then low.
  - Required: gpio_db[0] stays 0, rise stays 0, pend stays 0.
- Bounce: DB_CYCLES=4, gpio_in[1] toggles 1,0,1 each 2 cycles, then holds 1.
  - Required: gpio_db[1] rises exactly DB_CYCLES+1 edges after the final 0->1 toggle.
  - Required: exactly one rise[1] pulse.
- Pend/irq: edge_fall_en[2]=1, irq_en[2]=1, with gpio_db[2]=1 initially; drive gpio_in[2] low and hold.
  - Required: fall[2] pulses and pend[2]=1 on the update edge; irq=1 on the next edge.
  - Then pulse pend_clr[2]: pend[2]=0 on the next edge, irq=0 one edge later.
- Set/clear collision: pend_clr[3] asserted on the same edge rise[3] is produced, with edge_rise_en[3]=1.
  - Required: pend[3]=1 afterwards.
- Mask: edge_rise_en=0 with a rising edge on channel 0.
  - Required: rise[0] pulses, pend[0] stays 0; irq_en=0 with pend set gives irq=0.
